regfile_tagged: RTL and testbench

- Parametrised successor of the scalar register file, for the out-of-order (Tomasulo/ROB) core.
- Holds architectural registers plus a per-register busy bit and producer tag (ROB index).
- Has N combinational read ports with commit bypass, one issue (rename) port, one commit port, a flush and an outstanding-producer counter.
- Sits between decode/dispatch (reads, issue) and the ROB commit stage (commit, flush).

---
 rtl/regfile_tagged.sv | 136 +++++++++++++
 tb/tb_regfile_tagged.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_tagged.sv
// regfile_tagged: architectural register file for the out-of-order core.
// Each register carries a busy bit and the tag (ROB index) of the instruction
// that will produce its next value. Dispatch reads operands and renames
// destinations through the issue port. The ROB retires results through the
// commit port. A flush drops all pending producers.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   rdy               1 = run, 0 = hold all state (iss/cmt/flush ignored)
//   flush             clear every busy bit and tag; same-cycle issue dropped
//   iss_we/addr/tag   mark iss_addr busy, waiting on producer iss_tag
//   cmt_we/addr/tag/data  write cmt_data; clear busy if the tag still matches
//   rd_addr           NRD packed read addresses, port k at [k*AW +: AW]
//   rd_data/busy/tag  combinational read results with commit bypass
//   busy_cnt          registered number of busy registers
module regfile_tagged #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int TAGW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 iss_we,
  input  logic [AW-1:0]        iss_addr,
  input  logic [TAGW-1:0]      iss_tag,
  input  logic                 cmt_we,
  input  logic [AW-1:0]        cmt_addr,
  input  logic [TAGW-1:0]      cmt_tag,
  input  logic [XLEN-1:0]      cmt_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAGW-1:0]  rd_tag,
  output logic [AW:0]          busy_cnt
);

  logic [XLEN-1:0] regs [NREG];
  logic [TAGW-1:0] tag  [NREG];
  logic [NREG-1:0] busy;

  logic        cmt_fire;
  logic        cmt_clr;
  logic        iss_fire;
  logic        iss_was_busy;
  logic        cnt_inc;
  logic        cnt_dec;
  logic [AW:0] busy_cnt_nxt;

  assign cmt_fire = rdy && cmt_we && (cmt_addr != '0);
  assign iss_fire = rdy && iss_we && (iss_addr != '0) && !flush;

  // A commit retires the producer only if it is still the newest one recorded.
  assign cmt_clr = cmt_fire && busy[cmt_addr] && (tag[cmt_addr] == cmt_tag);

  // Busy state of the issue target after this cycle's commit has been applied.
  // An issue to a register that is being released counts as a fresh increment.
  assign iss_was_busy = busy[iss_addr] && !(cmt_clr && (cmt_addr == iss_addr));
  assign cnt_inc      = iss_fire && !iss_was_busy;
  assign cnt_dec      = cmt_clr;

  always_comb begin
    busy_cnt_nxt = busy_cnt;
    if (flush) begin
      busy_cnt_nxt = '0;
    end else begin
      busy_cnt_nxt = busy_cnt + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs     <= '{default: '0};
      tag      <= '{default: '0};
      busy     <= '0;
      busy_cnt <= '0;
    end else if (rdy) begin
      if (cmt_fire) begin
        regs[cmt_addr] <= cmt_data;
      end
      if (flush) begin
        busy <= '0;
        tag  <= '{default: '0};
      end else begin
        if (cmt_clr) begin
          busy[cmt_addr] <= 1'b0;
          tag[cmt_addr]  <= '0;
        end
        // Issue is later in the block so it wins busy/tag over a same-address commit.
        if (iss_fire) begin
          busy[iss_addr] <= 1'b1;
          tag[iss_addr]  <= iss_tag;
        end
      end
      busy_cnt <= busy_cnt_nxt;
    end
  end

  // Read ports see pre-edge state plus the committing value; a same-cycle
  // issue is deliberately invisible (sources are read before renaming).
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            b;
    logic [TAGW-1:0] t;

    assign a = rd_addr[k*AW +: AW];

    always_comb begin
      d = '0;
      b = 1'b0;
      t = '0;
      if (rst && (a != '0)) begin
        if (cmt_fire && (cmt_addr == a)) begin
          d = cmt_data;
          if (!cmt_clr) begin
            b = busy[a];
            t = busy[a] ? tag[a] : '0;
          end
        end else begin
          d = regs[a];
          b = busy[a];
          t = busy[a] ? tag[a] : '0;
        end
      end
    end

    assign rd_data[k*XLEN +: XLEN] = d;
    assign rd_busy[k]              = b;
    assign rd_tag[k*TAGW +: TAGW]  = t;
  end

endmodule

// File: tb/tb_regfile_tagged.sv
module tb_regfile_tagged;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int TAGW = 4;

  logic                 clk;
  logic                 rst;
  logic                 rdy;
  logic                 flush;
  logic                 iss_we;
  logic [AW-1:0]        iss_addr;
  logic [TAGW-1:0]      iss_tag;
  logic                 cmt_we;
  logic [AW-1:0]        cmt_addr;
  logic [TAGW-1:0]      cmt_tag;
  logic [XLEN-1:0]      cmt_data;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAGW-1:0]  rd_tag;
  logic [AW:0]          busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_tagged #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .TAGW(TAGW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .flush    (flush),
    .iss_we   (iss_we),
    .iss_addr (iss_addr),
    .iss_tag  (iss_tag),
    .cmt_we   (cmt_we),
    .cmt_addr (cmt_addr),
    .cmt_tag  (cmt_tag),
    .cmt_data (cmt_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .rd_tag   (rd_tag),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Advance one clock; inputs changed afterwards are away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input int a0, input int a1);
    rd_addr[0*AW +: AW] = AW'(a0);
    rd_addr[1*AW +: AW] = AW'(a1);
    #1;
  endtask

  task automatic idle();
    flush  = 1'b0;
    iss_we = 1'b0;
    cmt_we = 1'b0;
  endtask

  // Checks port k against expected data/busy/tag.
  task automatic chk_port(input string name, input int k,
                          input logic [XLEN-1:0] ed, input logic eb, input logic [TAGW-1:0] et);
    chk({name, "_data"}, 64'(rd_data[k*XLEN +: XLEN]), 64'(ed));
    chk({name, "_busy"}, 64'(rd_busy[k]), 64'(eb));
    chk({name, "_tag"},  64'(rd_tag[k*TAGW +: TAGW]), 64'(et));
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1;
    flush = 1'b0; iss_we = 1'b0; iss_addr = '0; iss_tag = '0;
    cmt_we = 1'b0; cmt_addr = '0; cmt_tag = '0; cmt_data = '0;
    rd_addr = '0;
    step(); step();

    // Reset: every register on both ports reads zero.
    for (int i = 0; i < NREG; i++) begin
      look(i, NREG - 1 - i);
      chk_port("rst_p0", 0, 32'h0, 1'b0, 4'h0);
      chk_port("rst_p1", 1, 32'h0, 1'b0, 4'h0);
    end
    chk("rst_cnt", 64'(busy_cnt), 64'd0);
    // A commit presented while in reset must not leak through the bypass.
    cmt_we = 1'b1; cmt_addr = 5'd3; cmt_tag = 4'd0; cmt_data = 32'hCAFE;
    look(3, 3);
    chk_port("rst_byp", 0, 32'h0, 1'b0, 4'h0);
    step();
    cmt_we = 1'b0;
    rst = 1'b1;
    look(3, 3);
    chk_port("rst_nowr", 0, 32'h0, 1'b0, 4'h0);

    // Issue x5 tag 3; same-cycle read does not see it.
    iss_we = 1'b1; iss_addr = 5'd5; iss_tag = 4'd3;
    look(5, 5);
    chk_port("iss5_same", 0, 32'h0, 1'b0, 4'h0);
    step(); idle();
    look(5, 5);
    chk_port("iss5_p0", 0, 32'h0, 1'b1, 4'd3);
    chk_port("iss5_p1", 1, 32'h0, 1'b1, 4'd3);
    chk("iss5_cnt", 64'(busy_cnt), 64'd1);

    // Commit x5 tag 3 with bypass.
    cmt_we = 1'b1; cmt_addr = 5'd5; cmt_tag = 4'd3; cmt_data = 32'hDEADBEEF;
    look(5, 0);
    chk_port("cmt5_byp", 0, 32'hDEADBEEF, 1'b0, 4'h0);
    chk_port("cmt5_x0", 1, 32'h0, 1'b0, 4'h0);
    step(); idle();
    look(5, 5);
    chk_port("cmt5_after", 0, 32'hDEADBEEF, 1'b0, 4'h0);
    chk("cmt5_cnt", 64'(busy_cnt), 64'd0);

    // x7: two producers, stale commit keeps busy.
    iss_we = 1'b1; iss_addr = 5'd7; iss_tag = 4'd2;
    step();
    iss_tag = 4'd9;
    step(); idle();
    look(7, 7);
    chk_port("reiss7", 0, 32'h0, 1'b1, 4'd9);
    chk("reiss7_cnt", 64'(busy_cnt), 64'd1);
    cmt_we = 1'b1; cmt_addr = 5'd7; cmt_tag = 4'd2; cmt_data = 32'h11;
    look(7, 7);
    chk_port("stale7_byp", 0, 32'h11, 1'b1, 4'd9);
    step(); idle();
    look(7, 7);
    chk_port("stale7", 0, 32'h11, 1'b1, 4'd9);
    chk("stale7_cnt", 64'(busy_cnt), 64'd1);
    cmt_we = 1'b1; cmt_addr = 5'd7; cmt_tag = 4'd9; cmt_data = 32'h22;
    step(); idle();
    look(7, 7);
    chk_port("final7", 0, 32'h22, 1'b0, 4'h0);
    chk("final7_cnt", 64'(busy_cnt), 64'd0);

    // x4: commit clears and issue re-marks in the same cycle.
    iss_we = 1'b1; iss_addr = 5'd4; iss_tag = 4'd1;
    step(); idle();
    chk("iss4_cnt", 64'(busy_cnt), 64'd1);
    cmt_we = 1'b1; cmt_addr = 5'd4; cmt_tag = 4'd1; cmt_data = 32'hA5A5;
    iss_we = 1'b1; iss_addr = 5'd4; iss_tag = 4'd6;
    look(4, 4);
    chk_port("same4_byp", 0, 32'hA5A5, 1'b0, 4'h0);
    step(); idle();
    look(4, 4);
    chk_port("same4", 0, 32'hA5A5, 1'b1, 4'd6);
    chk("same4_cnt", 64'(busy_cnt), 64'd1);

    // Retire x4 while issuing x1, then x2, x3 -> three busy.
    cmt_we = 1'b1; cmt_addr = 5'd4; cmt_tag = 4'd6; cmt_data = 32'h44;
    iss_we = 1'b1; iss_addr = 5'd1; iss_tag = 4'd1;
    step();
    cmt_we = 1'b0;
    iss_addr = 5'd2; iss_tag = 4'd2;
    step();
    iss_addr = 5'd3; iss_tag = 4'd3;
    step(); idle();
    chk("three_cnt", 64'(busy_cnt), 64'd3);

    // Flush with same-cycle issue x8 and commit x2.
    flush = 1'b1;
    iss_we = 1'b1; iss_addr = 5'd8; iss_tag = 4'd5;
    cmt_we = 1'b1; cmt_addr = 5'd2; cmt_tag = 4'd7; cmt_data = 32'h55;
    step(); idle();
    chk("flush_cnt", 64'(busy_cnt), 64'd0);
    look(1, 2);
    chk_port("flush_x1", 0, 32'h0, 1'b0, 4'h0);
    chk_port("flush_x2", 1, 32'h55, 1'b0, 4'h0);
    look(3, 8);
    chk_port("flush_x3", 0, 32'h0, 1'b0, 4'h0);
    chk_port("flush_x8", 1, 32'h0, 1'b0, 4'h0);
    look(4, 4);
    chk_port("flush_x4", 0, 32'h44, 1'b0, 4'h0);

    // Pause: everything asserted, nothing changes, no bypass.
    iss_we = 1'b1; iss_addr = 5'd9; iss_tag = 4'd4;
    step(); idle();
    chk("pre_pause_cnt", 64'(busy_cnt), 64'd1);
    rdy = 1'b0;
    flush = 1'b1;
    iss_we = 1'b1; iss_addr = 5'd10; iss_tag = 4'd5;
    cmt_we = 1'b1; cmt_addr = 5'd9; cmt_tag = 4'd4; cmt_data = 32'h99;
    look(9, 10);
    chk_port("pause_byp", 0, 32'h0, 1'b1, 4'd4);
    step(); step(); idle();
    rdy = 1'b1;
    look(9, 10);
    chk_port("pause_x9", 0, 32'h0, 1'b1, 4'd4);
    chk_port("pause_x10", 1, 32'h0, 1'b0, 4'h0);
    chk("pause_cnt", 64'(busy_cnt), 64'd1);

    // Register 0 ignores issue and commit.
    iss_we = 1'b1; iss_addr = 5'd0; iss_tag = 4'd7;
    cmt_we = 1'b1; cmt_addr = 5'd0; cmt_tag = 4'd7; cmt_data = 32'hFFFF;
    look(0, 0);
    chk_port("x0_byp", 0, 32'h0, 1'b0, 4'h0);
    step(); idle();
    look(0, 0);
    chk_port("x0_after", 0, 32'h0, 1'b0, 4'h0);
    chk("x0_cnt", 64'(busy_cnt), 64'd1);

    // Asynchronous reset mid-run clears without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    look(2, 9);
    chk_port("arst_x2", 0, 32'h0, 1'b0, 4'h0);
    chk_port("arst_x9", 1, 32'h0, 1'b0, 4'h0);
    chk("arst_cnt", 64'(busy_cnt), 64'd0);
    step();
    rst = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
